// File: rtl/sys_defs.sv
// Shared fetch-stage definitions: FSM state encoding, HALT encoding and the
// per-slot output bundle used by fetch_ctrl.
package sys_defs;

  localparam int          NUM_SUPER = 2;
  localparam logic [31:0] HALT_INST = 32'h0000_0555;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MISS     = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } FETCH_STATE_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] npc;
    logic [31:0] ir;
    logic [63:0] target;
    logic        valid;
  } IF_OUT_t;

endpackage

// File: rtl/fetch_slot_pack.sv
// Combinational slot packer: builds the contiguous valid mask, counts the
// valid slots and flags a HALT among them.
module fetch_slot_pack #(
  parameter int          NUM_SUPER = 2,
  parameter logic [31:0] HALT_INST = 32'h0000_0555
) (
  input  logic                             run,
  input  logic                             rollback_en,
  input  logic [NUM_SUPER-1:0]             icache_valid,
  input  logic [NUM_SUPER*32-1:0]          icache_data,
  output logic [NUM_SUPER-1:0]             valid,
  output logic [$clog2(NUM_SUPER+1)-1:0]   count,
  output logic                             halt_hit
);

  localparam int CNT_BITS = $clog2(NUM_SUPER + 1);

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    valid    = '0;
    count    = '0;
    halt_hit = 1'b0;
    valid[0] = run & icache_valid[0] & ~rollback_en;
    // A slot is only usable if all lower slots are, and none of them is a HALT.
    for (int i = 1; i < NUM_SUPER; i++) begin
      valid[i] = valid[i-1] & icache_valid[i]
               & (icache_data[(i-1)*32 +: 32] != HALT_INST);
    end
    for (int i = 0; i < NUM_SUPER; i++) begin
      count    = count + CNT_BITS'(valid[i]);
      halt_hit = halt_hit | (valid[i] & (icache_data[i*32 +: 32] == HALT_INST));
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Superscalar fetch sequencer: owns the fetch PC, the RUN/MISS/REDIRECT/HALTED
// FSM and the saturating fetch/miss performance counters.
module fetch_ctrl #(
  parameter int          NUM_SUPER = sys_defs::NUM_SUPER,
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] HALT_INST = sys_defs::HALT_INST,
  parameter int          CNT_W     = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    fetch_en,
  input  logic                    rollback_en,
  input  logic [63:0]             rollback_pc,
  input  logic [NUM_SUPER-1:0]    Icache_valid,
  input  logic [NUM_SUPER*32-1:0] Icache_data,
  output logic [NUM_SUPER*64-1:0] proc2Icache_addr,
  output logic [NUM_SUPER*64-1:0] if_PC_out,
  output logic [NUM_SUPER*64-1:0] if_NPC_out,
  output logic [NUM_SUPER*32-1:0] if_IR_out,
  output logic [NUM_SUPER*64-1:0] if_target_out,
  output logic [NUM_SUPER-1:0]    if_valid_inst_out,
  output logic [1:0]              fetch_state,
  output logic [CNT_W-1:0]        fetched_cnt,
  output logic [CNT_W-1:0]        miss_cnt
);

  import sys_defs::*;

  localparam int N_W = $clog2(NUM_SUPER + 1);

  FETCH_STATE_t          state;
  logic [63:0]           pc;
  logic [NUM_SUPER-1:0]  slot_valid;
  logic [N_W-1:0]        n_valid;
  logic                  halt_hit;
  logic                  accept;
  logic [CNT_W:0]        fetched_sum;
  IF_OUT_t               slot [NUM_SUPER];

  fetch_slot_pack #(
    .NUM_SUPER (NUM_SUPER),
    .HALT_INST (HALT_INST)
  ) u_pack (
    .run          (state == RUN),
    .rollback_en  (rollback_en),
    .icache_valid (Icache_valid),
    .icache_data  (Icache_data),
    .valid        (slot_valid),
    .count        (n_valid),
    .halt_hit     (halt_hit)
  );

  assign accept      = en & fetch_en & slot_valid[0];
  assign fetched_sum = {1'b0, fetched_cnt} + (CNT_W+1)'(n_valid);
  assign fetch_state = state;

  for (genvar i = 0; i < NUM_SUPER; i++) begin : g_slot
    assign slot[i] = '{pc:     pc + 64'(4 * i),
                       npc:    pc + 64'(4 * i + 4),
                       ir:     slot_valid[i] ? Icache_data[i*32 +: 32] : 32'h0,
                       target: pc + 64'(4 * i + 4),
                       valid:  slot_valid[i]};
    assign proc2Icache_addr[i*64 +: 64] = slot[i].pc;
    assign if_PC_out[i*64 +: 64]        = slot[i].pc;
    assign if_NPC_out[i*64 +: 64]       = slot[i].npc;
    assign if_target_out[i*64 +: 64]    = slot[i].target;
    assign if_IR_out[i*32 +: 32]        = slot[i].ir;
    assign if_valid_inst_out[i]         = slot[i].valid;
  end

  // NOTE: sequential state uses non-blocking assignments only; rollback
  // outranks en so a redirect is never lost while the stage is stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= RUN;
      fetched_cnt <= '0;
      miss_cnt    <= '0;
    end else begin
      if (en && state == MISS && miss_cnt != '1) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
      if (rollback_en) begin
        pc    <= rollback_pc;
        state <= REDIRECT;
      end else if (en) begin
        case (state)
          RUN: begin
            if (accept) begin
              pc          <= pc + (64'(n_valid) << 2);
              fetched_cnt <= fetched_sum[CNT_W] ? '1 : fetched_sum[CNT_W-1:0];
              if (halt_hit) state <= HALTED;
            end else if (!Icache_valid[0]) begin
              state <= MISS;
            end
          end
          MISS:     if (Icache_valid[0]) state <= RUN;
          REDIRECT: state <= RUN;
          HALTED:   state <= HALTED;
          default:  state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scenario bench for fetch_ctrl: each step pushes its expected outputs to a
// scoreboard queue, which is popped and compared mid-cycle.
module tb_fetch_ctrl;
  import sys_defs::*;

  localparam logic [31:0] HALT = 32'h0000_0555;

  logic          clock = 1'b0;
  logic          reset, en, fetch_en, rollback_en;
  logic [63:0]   rollback_pc;
  logic [1:0]    Icache_valid;
  logic [63:0]   Icache_data;
  logic [127:0]  proc2Icache_addr, if_PC_out, if_NPC_out, if_target_out;
  logic [63:0]   if_IR_out;
  logic [1:0]    if_valid_inst_out, fetch_state;
  logic [31:0]   fetched_cnt, miss_cnt;

  fetch_ctrl #(.NUM_SUPER(2), .RESET_PC(64'h0), .HALT_INST(HALT), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .en(en), .fetch_en(fetch_en),
    .rollback_en(rollback_en), .rollback_pc(rollback_pc),
    .Icache_valid(Icache_valid), .Icache_data(Icache_data),
    .proc2Icache_addr(proc2Icache_addr), .if_PC_out(if_PC_out),
    .if_NPC_out(if_NPC_out), .if_IR_out(if_IR_out), .if_target_out(if_target_out),
    .if_valid_inst_out(if_valid_inst_out), .fetch_state(fetch_state),
    .fetched_cnt(fetched_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rst, en, fe, rb;
    logic [63:0] rbpc;
    logic [1:0]  iv;
    logic        halt0;
    logic [63:0] epc;
    logic [1:0]  evld;
    logic [1:0]  est;
    logic [31:0] efc, emc;
  } step_t;

  typedef struct {
    logic [511:0] addrs;
    logic [1:0]   vld;
    logic [1:0]   st;
    logic [63:0]  cnts;
    logic [63:0]  ir;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] word(input logic [63:0] a, input logic h);
    return h ? HALT : {16'hA5A5, a[15:0]};
  endfunction

  function automatic step_t st(input logic rst, input logic e, input logic fe,
      input logic rb, input logic [63:0] rbpc, input logic [1:0] iv, input logic h,
      input logic [63:0] epc, input logic [1:0] evld, input logic [1:0] est,
      input logic [31:0] efc, input logic [31:0] emc);
    step_t s;
    s.rst = rst; s.en = e; s.fe = fe; s.rb = rb; s.rbpc = rbpc; s.iv = iv;
    s.halt0 = h; s.epc = epc; s.evld = evld; s.est = est; s.efc = efc; s.emc = emc;
    return s;
  endfunction

  // Drive one cycle of stimulus; the I-cache model answers for the PC the bench expects.
  task automatic drive(input step_t s);
    exp_t        e;
    logic [63:0] a0, a1;
    a0 = s.epc;
    a1 = s.epc + 64'd4;
    reset = s.rst; en = s.en; fetch_en = s.fe;
    rollback_en = s.rb; rollback_pc = s.rbpc; Icache_valid = s.iv;
    Icache_data = {word(a1, 1'b0), word(a0, s.halt0)};
    e.addrs = {a1, a0, a1, a0, a1 + 64'd4, a1, a1 + 64'd4, a1};
    e.vld   = s.evld;
    e.st    = s.est;
    e.cnts  = {s.efc, s.emc};
    e.ir    = {s.evld[1] ? word(a1, 1'b0) : 32'h0, s.evld[0] ? word(a0, s.halt0) : 32'h0};
    sb.push_back(e);
  endtask

  task automatic test_reset();
    step_t q[$];
    reset = 1'b1; en = 1'b1; fetch_en = 1'b1; rollback_en = 1'b0;
    rollback_pc = '0; Icache_valid = 2'b00; Icache_data = '0;
    @(posedge clock); #1;
    q.push_back(st(1, 1, 1, 0, 0, 2'b00, 0, 64'h0, 2'b00, RUN, 0, 0));
    foreach (q[k]) begin
      exp_t e;
      drive(q[k]);
      @(negedge clock);
      e = sb.pop_front();
      vectors++; if ({proc2Icache_addr, if_PC_out, if_NPC_out, if_target_out} !== e.addrs) begin miscompares++; $display("FAIL reset.addr got %h want %h", {proc2Icache_addr, if_PC_out, if_NPC_out, if_target_out}, e.addrs); end
      vectors++; if (if_valid_inst_out !== e.vld) begin miscompares++; $display("FAIL reset.valid got %b want %b", if_valid_inst_out, e.vld); end
      vectors++; if (fetch_state !== e.st) begin miscompares++; $display("FAIL reset.state got %0d want %0d", fetch_state, e.st); end
      vectors++; if ({fetched_cnt, miss_cnt} !== e.cnts) begin miscompares++; $display("FAIL reset.cnt got %h want %h", {fetched_cnt, miss_cnt}, e.cnts); end
      vectors++; if (if_IR_out !== e.ir) begin miscompares++; $display("FAIL reset.ir got %h want %h", if_IR_out, e.ir); end
      @(posedge clock); #1;
    end
  endtask

  // Scenario table runner per feature; each scenario owns its comparisons.
  task automatic test_scenario(input string tag, input int which);
    step_t q[$];
    case (which)
      0: begin  // full hits
        q.push_back(st(0, 1, 1, 0, 0, 2'b11, 0, 64'h00, 2'b11, RUN, 0, 0));
        q.push_back(st(0, 1, 1, 0, 0, 2'b11, 0, 64'h08, 2'b11, RUN, 2, 0));
      end
      1: begin  // miss and re-lookup
        q.push_back(st(0, 1, 1, 0, 0, 2'b10, 0, 64'h10, 2'b00, RUN,  4, 0));
        q.push_back(st(0, 1, 1, 0, 0, 2'b10, 0, 64'h10, 2'b00, MISS, 4, 0));
        q.push_back(st(0, 1, 1, 0, 0, 2'b00, 0, 64'h10, 2'b00, MISS, 4, 1));
        q.push_back(st(0, 1, 1, 0, 0, 2'b00, 0, 64'h10, 2'b00, MISS, 4, 2));
        q.push_back(st(0, 1, 1, 0, 0, 2'b11, 0, 64'h10, 2'b00, MISS, 4, 3));
        q.push_back(st(0, 1, 1, 0, 0, 2'b11, 0, 64'h10, 2'b11, RUN,  4, 4));
      end
      2: begin  // partial hit, then buffer stall
        q.push_back(st(0, 1, 1, 0, 0, 2'b01, 0, 64'h18, 2'b01, RUN, 6, 4));
        q.push_back(st(0, 1, 0, 0, 0, 2'b11, 0, 64'h1C, 2'b11, RUN, 7, 4));
        q.push_back(st(0, 1, 0, 0, 0, 2'b11, 0, 64'h1C, 2'b11, RUN, 7, 4));
        q.push_back(st(0, 1, 1, 0, 0, 2'b11, 0, 64'h1C, 2'b11, RUN, 7, 4));
      end
      3: begin  // HALT, then rollback out of it
        q.push_back(st(0, 1, 1, 0, 0,      2'b11, 1, 64'h24, 2'b01, RUN,      9,  4));
        q.push_back(st(0, 1, 1, 0, 0,      2'b11, 0, 64'h28, 2'b00, HALTED,   10, 4));
        q.push_back(st(0, 1, 1, 0, 0,      2'b11, 0, 64'h28, 2'b00, HALTED,   10, 4));
        q.push_back(st(0, 1, 1, 1, 64'h40, 2'b11, 0, 64'h28, 2'b00, HALTED,   10, 4));
        q.push_back(st(0, 1, 1, 0, 0,      2'b11, 0, 64'h40, 2'b00, REDIRECT, 10, 4));
        q.push_back(st(0, 1, 1, 0, 0,      2'b11, 0, 64'h40, 2'b11, RUN,      10, 4));
      end
      4: begin  // rollback squashes a same-cycle accept
        q.push_back(st(0, 1, 1, 1, 64'h20,  2'b11, 0, 64'h48,  2'b00, RUN,      12, 4));
        q.push_back(st(0, 1, 1, 0, 0,       2'b11, 0, 64'h20,  2'b00, REDIRECT, 12, 4));
        q.push_back(st(0, 1, 1, 1, 64'h100, 2'b11, 0, 64'h20,  2'b00, RUN,      12, 4));
        q.push_back(st(0, 1, 1, 0, 0,       2'b11, 0, 64'h100, 2'b00, REDIRECT, 12, 4));
        q.push_back(st(0, 1, 1, 0, 0,       2'b11, 0, 64'h100, 2'b11, RUN,      12, 4));
      end
      default: begin  // reset in MISS, then en-low hold
        q.push_back(st(0, 1, 1, 0, 0, 2'b00, 0, 64'h108, 2'b00, RUN,  14, 4));
        q.push_back(st(0, 1, 1, 0, 0, 2'b00, 0, 64'h108, 2'b00, MISS, 14, 4));
        q.push_back(st(1, 1, 1, 0, 0, 2'b00, 0, 64'h108, 2'b00, MISS, 14, 5));
        q.push_back(st(0, 1, 1, 0, 0, 2'b00, 0, 64'h000, 2'b00, RUN,  0,  0));
        q.push_back(st(0, 0, 1, 0, 0, 2'b00, 0, 64'h000, 2'b00, MISS, 0,  0));
        q.push_back(st(0, 0, 1, 0, 0, 2'b11, 0, 64'h000, 2'b00, MISS, 0,  0));
        q.push_back(st(0, 1, 1, 0, 0, 2'b11, 0, 64'h000, 2'b00, MISS, 0,  0));
        q.push_back(st(0, 1, 1, 0, 0, 2'b11, 0, 64'h000, 2'b11, RUN,  0,  1));
      end
    endcase
    foreach (q[k]) begin
      exp_t e;
      drive(q[k]);
      @(negedge clock);
      e = sb.pop_front();
      vectors++; if ({proc2Icache_addr, if_PC_out, if_NPC_out, if_target_out} !== e.addrs) begin miscompares++; $display("FAIL %s[%0d].addr pc0 got %h want %h", tag, k, if_PC_out[63:0], e.addrs[319:256]); end
      vectors++; if (if_valid_inst_out !== e.vld) begin miscompares++; $display("FAIL %s[%0d].valid got %b want %b", tag, k, if_valid_inst_out, e.vld); end
      vectors++; if (fetch_state !== e.st) begin miscompares++; $display("FAIL %s[%0d].state got %0d want %0d", tag, k, fetch_state, e.st); end
      vectors++; if ({fetched_cnt, miss_cnt} !== e.cnts) begin miscompares++; $display("FAIL %s[%0d].cnt got %h want %h", tag, k, {fetched_cnt, miss_cnt}, e.cnts); end
      vectors++; if (if_IR_out !== e.ir) begin miscompares++; $display("FAIL %s[%0d].ir got %h want %h", tag, k, if_IR_out, e.ir); end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    test_reset();
    test_scenario("run_hits", 0);
    test_scenario("miss", 1);
    test_scenario("partial_stall", 2);
    test_scenario("halt", 3);
    test_scenario("rollback_squash", 4);
    test_scenario("reset_in_miss", 5);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard.leftover got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
